// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared state encodings and song-table sizing for the playback path
package music_pkg;

    localparam int SONG_NUM = 3;
    localparam int IDX_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // One event per cycle after priority resolution (play > next > prev > song_end).
    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_PLAY = 3'd1,
        EV_NEXT = 3'd2,
        EV_PREV = 3'd3,
        EV_END  = 3'd4
    } event_e;

endpackage

// File: rtl/key_lockout.sv
// rtl/key_lockout.sv - gates debounced key pulses behind a post-accept lockout down-counter
module key_lockout #(
    parameter logic [23:0] LOCK_CNT = 24'd2_500_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic play_i,
    input  logic next_i,
    input  logic prev_i,
    input  logic lock_req_i,
    output logic play_o,
    output logic next_o,
    output logic prev_o
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic        unlocked;

    assign unlocked = (cnt_q == 24'd0);
    assign play_o   = play_i & unlocked;
    assign next_o   = next_i & unlocked;
    assign prev_o   = prev_i & unlocked;

    // Load on an accepted key, otherwise count down to zero; keys while locked are simply dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (lock_req_i && unlocked) begin
            cnt_d = LOCK_CNT - 24'd1;
        end else if (!unlocked) begin
            cnt_d = cnt_q - 24'd1;
        end
    end

    // Lockout counter register; reset clears any lockout in progress.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/play_ctrl.sv
// rtl/play_ctrl.sv - playback state machine, song index stepping and registered player outputs
module play_ctrl
    import music_pkg::*;
#(
    parameter logic [23:0] LOCK_CNT = 24'd2_500_000,
    parameter logic        LOOP_ALL = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             play_flag,
    input  logic             next_flag,
    input  logic             prev_flag,
    input  logic             song_end,
    output logic [IDX_W-1:0] song_idx,
    output logic             playing,
    output logic             restart
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_NUM - 1);

    logic             play_g;
    logic             next_g;
    logic             prev_g;
    logic             lock_req;
    event_e           ev_q;
    event_e           ev_d;
    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;
    logic             playing_q;
    logic             restart_q;
    logic             restart_d;

    // Any key that gets through the gate is accepted and (re)arms the lockout, even if it loses priority.
    assign lock_req = play_g | next_g | prev_g;

    key_lockout #(
        .LOCK_CNT(LOCK_CNT)
    ) u_lockout (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .play_i    (play_flag),
        .next_i    (next_flag),
        .prev_i    (prev_flag),
        .lock_req_i(lock_req),
        .play_o    (play_g),
        .next_o    (next_g),
        .prev_o    (prev_g)
    );

    assign idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    assign idx_dec = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);

    // Resolve simultaneous inputs to a single event; losers, including song_end, are dropped.
    always_comb begin
        ev_d = EV_NONE;
        if (play_g) begin
            ev_d = EV_PLAY;
        end else if (next_g) begin
            ev_d = EV_NEXT;
        end else if (prev_g) begin
            ev_d = EV_PREV;
        end else if (song_end) begin
            ev_d = EV_END;
        end
    end

    // Accepted event register; the FSM acts on it at the following edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ev_q <= EV_NONE;
        end else begin
            ev_q <= ev_d;
        end
    end

    // Next-state, next-index and restart request for the pending event.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        restart_d = 1'b0;
        case (ev_q)
            EV_PLAY: begin
                case (state_q)
                    ST_IDLE: begin
                        state_d   = ST_PLAY;
                        restart_d = 1'b1;
                    end
                    ST_PLAY:  state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_PLAY;
                    default:  state_d = ST_IDLE;
                endcase
            end
            EV_NEXT: begin
                idx_d     = idx_inc;
                restart_d = 1'b1;
            end
            EV_PREV: begin
                idx_d     = idx_dec;
                restart_d = 1'b1;
            end
            EV_END: begin
                if (state_q == ST_PLAY) begin
                    idx_d     = idx_inc;
                    restart_d = 1'b1;
                    if ((idx_q == IDX_LAST) && !LOOP_ALL) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // State, index and output registers; playing is registered alongside the state it reflects.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            playing_q <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            playing_q <= (state_d == ST_PLAY);
            restart_q <= restart_d;
        end
    end

    assign song_idx = idx_q;
    assign playing  = playing_q;
    assign restart  = restart_q;

endmodule

// File: tb/tb_play_ctrl.sv
// tb/tb_play_ctrl.sv - scoreboard bench for play_ctrl with looping and non-looping instances
module tb_play_ctrl;
    import music_pkg::*;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             play_flag = 1'b0;
    logic             next_flag = 1'b0;
    logic             prev_flag = 1'b0;
    logic             song_end  = 1'b0;
    logic [IDX_W-1:0] l_idx;
    logic             l_playing;
    logic             l_restart;
    logic [IDX_W-1:0] s_idx;
    logic             s_playing;
    logic             s_restart;

    int tests = 0;
    int fails = 0;

    // Expected output events {restart, playing, idx}
    logic [3:0] q_l[$];
    logic [3:0] q_s[$];
    logic [2:0] last_l = '0;
    logic [2:0] last_s = '0;

    always #10 sys_clk = ~sys_clk;

    play_ctrl #(.LOCK_CNT(24'd10), .LOOP_ALL(1'b1)) u_loop (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .play_flag(play_flag),
        .next_flag(next_flag),
        .prev_flag(prev_flag),
        .song_end (song_end),
        .song_idx (l_idx),
        .playing  (l_playing),
        .restart  (l_restart)
    );

    play_ctrl #(.LOCK_CNT(24'd10), .LOOP_ALL(1'b0)) u_stop (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .play_flag(play_flag),
        .next_flag(next_flag),
        .prev_flag(prev_flag),
        .song_end (song_end),
        .song_idx (s_idx),
        .playing  (s_playing),
        .restart  (s_restart)
    );

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {restart,playing,idx}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Loop instance monitor: any restart pulse or change of playing/idx is an output event.
    always @(negedge sys_clk) begin : mon_loop
        logic [3:0] cur;
        cur = {l_restart, l_playing, l_idx};
        if (!sys_rst_n) begin
            last_l = cur[2:0];
        end else if (cur[3] || (cur[2:0] != last_l)) begin
            last_l = cur[2:0];
            if (q_l.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL loop_spurious: got event %b expected none at %0t", cur, $time);
            end else begin
                chk("loop_evt", cur, q_l.pop_front());
            end
        end
    end

    // Stop instance monitor, same event rule.
    always @(negedge sys_clk) begin : mon_stop
        logic [3:0] cur;
        cur = {s_restart, s_playing, s_idx};
        if (!sys_rst_n) begin
            last_s = cur[2:0];
        end else if (cur[3] || (cur[2:0] != last_s)) begin
            last_s = cur[2:0];
            if (q_s.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stop_spurious: got event %b expected none at %0t", cur, $time);
            end else begin
                chk("stop_evt", cur, q_s.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Drive flags for exactly one sampling edge; caller is just after a rising edge.
    task automatic pulse(input logic p, input logic n, input logic pr, input logic e);
        play_flag = p;
        next_flag = n;
        prev_flag = pr;
        song_end  = e;
        tick(1);
        play_flag = 1'b0;
        next_flag = 1'b0;
        prev_flag = 1'b0;
        song_end  = 1'b0;
    endtask

    task automatic exp_both(input logic r, input logic p, input logic [1:0] i);
        q_l.push_back({r, p, i});
        q_s.push_back({r, p, i});
    endtask

    initial begin
        sys_rst_n = 1'b0;
        tick(3);
        chk("reset_loop", {l_restart, l_playing, l_idx}, 4'b0000);
        chk("reset_stop", {s_restart, s_playing, s_idx}, 4'b0000);
        sys_rst_n = 1'b1;
        tick(2);

        // IDLE + play -> PLAY idx 0 with restart
        exp_both(1'b1, 1'b1, 2'd0); pulse(1, 0, 0, 0); tick(12);
        // next steps and wraps upward, prev wraps downward
        exp_both(1'b1, 1'b1, 2'd1); pulse(0, 1, 0, 0); tick(12);
        exp_both(1'b1, 1'b1, 2'd2); pulse(0, 1, 0, 0); tick(12);
        exp_both(1'b1, 1'b1, 2'd0); pulse(0, 1, 0, 0); tick(12);
        exp_both(1'b1, 1'b1, 2'd2); pulse(0, 0, 1, 0); tick(12);

        // Lockout: accepted next, another 5 cycles later dropped, third 11 cycles later accepted
        exp_both(1'b1, 1'b1, 2'd0); pulse(0, 1, 0, 0);
        tick(4);                    pulse(0, 1, 0, 0);
        tick(5);
        exp_both(1'b1, 1'b1, 2'd1); pulse(0, 1, 0, 0); tick(12);

        // play and next together in PLAY: pause wins, index held, no restart
        exp_both(1'b0, 1'b0, 2'd1); pulse(1, 1, 0, 0); tick(12);
        // PAUSE + play resumes without restart
        exp_both(1'b0, 1'b1, 2'd1); pulse(1, 0, 0, 0); tick(12);
        exp_both(1'b1, 1'b1, 2'd2); pulse(0, 1, 0, 0); tick(12);

        // song_end on last song: loop instance wraps and plays, stop instance goes idle
        q_l.push_back(4'b1100);
        q_s.push_back(4'b1000);
        pulse(0, 0, 0, 1); tick(3);
        // song_end again: loop advances, stop instance (IDLE) ignores it
        q_l.push_back(4'b1101);
        pulse(0, 0, 0, 1); tick(3);

        // Loop: PLAY idx1 -> next -> idx2; Stop: IDLE idx0 -> next -> idx1
        q_l.push_back(4'b1110); q_s.push_back(4'b1001); pulse(0, 1, 0, 0); tick(12);
        // Loop pauses at idx2; Stop starts playing idx1
        q_l.push_back(4'b0010); q_s.push_back(4'b1101); pulse(1, 0, 0, 0); tick(12);
        // prev: Loop PAUSE idx1 with restart; Stop PLAY idx0
        q_l.push_back(4'b1001); q_s.push_back(4'b1100); pulse(0, 0, 1, 0); tick(3);

        // Reset during the lockout from the prev above
        sys_rst_n = 1'b0;
        #1;
        chk("midreset_loop", {l_restart, l_playing, l_idx}, 4'b0000);
        chk("midreset_stop", {s_restart, s_playing, s_idx}, 4'b0000);
        tick(2);
        sys_rst_n = 1'b1;
        // First next after reset must be accepted
        exp_both(1'b1, 1'b0, 2'd1); pulse(0, 1, 0, 0); tick(15);

        chk_int("loop_queue_drained", q_l.size(), 0);
        chk_int("stop_queue_drained", q_s.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
